// File: rtl/md_sched_unit.sv
// Multi-cycle multiply/divide scheduler owning the architectural HI/LO registers.
// Results are computed at issue into shadow registers and committed after a fixed busy latency.
module md_sched_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     shadow_hi_q, shadow_hi_d;
    logic [31:0]     shadow_lo_q, shadow_lo_d;
    logic            commit_q, commit_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;

    // Divide by zero substitutes a divisor of 1 so the datapath never produces X; the result is discarded.
    always_comb begin
        prod_s  = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u  = {32'd0, src_a} * {32'd0, src_b};
        divisor = (src_b == 32'd0) ? 32'd1 : src_b;
        quot_u  = src_a / divisor;
        rem_u   = src_a % divisor;
        if (src_a == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(src_a) / $signed(divisor);
            rem_s  = $signed(src_a) % $signed(divisor);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        commit_d    = commit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0: begin
                            shadow_hi_d = prod_s[63:32];
                            shadow_lo_d = prod_s[31:0];
                            commit_d    = 1'b1;
                            cnt_d       = CW'(MULT_CYCLES);
                            state_d     = RUN;
                        end
                        3'd1: begin
                            shadow_hi_d = prod_u[63:32];
                            shadow_lo_d = prod_u[31:0];
                            commit_d    = 1'b1;
                            cnt_d       = CW'(MULT_CYCLES);
                            state_d     = RUN;
                        end
                        3'd2: begin
                            shadow_hi_d = rem_s;
                            shadow_lo_d = quot_s;
                            commit_d    = (src_b != 32'd0);
                            cnt_d       = CW'(DIV_CYCLES);
                            state_d     = RUN;
                        end
                        3'd3: begin
                            shadow_hi_d = rem_u;
                            shadow_lo_d = quot_u;
                            commit_d    = (src_b != 32'd0);
                            cnt_d       = CW'(DIV_CYCLES);
                            state_d     = RUN;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= CW'(1)) begin
                    if (commit_q) begin
                        hi_d = shadow_hi_q;
                        lo_d = shadow_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            commit_q    <= commit_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched_unit.sv
// Scoreboard bench for md_sched_unit: a reference model queues expected commits,
// and a monitor checks busy length and HI/LO whenever busy falls.
module tb_md_sched_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic [31:0] hi, lo, rd_data;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          run_len = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_sched_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd_hi   (rd_hi),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: measures each busy pulse and checks the committed result when it ends.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else if (busy === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_commit actual=busy_len %0d required=no operation pending", run_len);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("busy_len", run_len, mon_e.cycles);
                checkOutput("commit_hi", hi, mon_e.hi);
                checkOutput("commit_lo", lo, mon_e.lo);
                checkOutput("commit_rd_data", rd_data, rd_hi ? mon_e.hi : mon_e.lo);
            end
            run_len = 0;
        end
    end

    task automatic driveOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        rd_hi = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("[TB] FAIL busy_timeout actual=still busy required=idle within 60 cycles");
        end
    endtask

    // Reference model: architectural result of one md operation from plain integer arithmetic.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output exp_t e);
        logic [63:0] p;
        longint      q, r;
        e.hi = model_hi;
        e.lo = model_lo;
        e.cycles = (op < 3'd2) ? MULT_N : DIV_N;
        case (op)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            3'd2: if (b != 32'd0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                e.hi = r[31:0];
                e.lo = q[31:0];
            end
            3'd3: if (b != 32'd0) begin
                e.hi = a % b;
                e.lo = a / b;
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (op < 3'd4) begin
            modelOp(op, a, b, e);
            model_hi = e.hi;
            model_lo = e.lo;
            expq.push_back(e);
            driveOp(op, a, b);
            waitIdle();
        end else begin
            if (op == 3'd4) model_hi = a;
            if (op == 3'd5) model_lo = a;
            driveOp(op, a, b);
            @(negedge clk);
            checkOutput("direct_busy", 32'(busy), 32'd0);
            checkOutput("direct_hi", hi, model_hi);
            checkOutput("direct_lo", lo, model_lo);
            checkOutput("direct_rd_data", rd_data, rd_hi ? model_hi : model_lo);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=time limit reached required=run complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic [2:0]  op;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_rd_data", rd_data, 32'd0);

        // Reset in the middle of a mult aborts it with no later commit.
        driveOp(3'd0, 32'd3, 32'd4);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("abort_late_busy", 32'(busy), 32'd0);
        checkOutput("abort_late_hi", hi, 32'd0);
        checkOutput("abort_late_lo", lo, 32'd0);

        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(3'd3, 32'd7, 32'd2);
        applyStimulus(3'd4, 32'h11, 32'd0);
        applyStimulus(3'd5, 32'h22, 32'd0);
        applyStimulus(3'd2, 32'd5, 32'd0);
        applyStimulus(3'd3, 32'd9, 32'd0);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0);
        rd_hi = 1'b1;
        #1;
        checkOutput("rd_sel_hi", rd_data, 32'hDEAD_BEEF);
        rd_hi = 1'b0;
        #1;
        checkOutput("rd_sel_lo", rd_data, model_lo);

        // A start arriving while busy must leave the in-flight result and timing untouched.
        modelOp(3'd0, 32'd2, 32'd3, e);
        model_hi = e.hi;
        model_lo = e.lo;
        expq.push_back(e);
        driveOp(3'd0, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'd5;
        src_a = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        @(negedge clk);
        checkOutput("ignored_lo", lo, 32'd6);
        checkOutput("ignored_hi", hi, 32'd0);

        applyStimulus(3'd6, 32'h1234_5678, 32'd1);
        applyStimulus(3'd7, 32'h8765_4321, 32'd2);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) a = 32'($signed(32'($urandom_range(0, 200))) - 100);
            applyStimulus(op, a, b);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
